// File: rtl/sync_fifo_pkg.sv
// Shared defaults for the sync_fifo block and its storage sub-module.
package sync_fifo_pkg;
    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 8;
endpackage

// File: rtl/sync_fifo_mem.sv
// width x depth register-array RAM: synchronous write port, registered read port.
// Read data appears one cycle after i_rd_en and holds otherwise; rst clears only the read register.
module sync_fifo_mem
    import sync_fifo_pkg::*;
#(
    parameter int width = DEF_WIDTH,
    parameter int depth = DEF_DEPTH,
    localparam int AW   = $clog2(depth)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_wr_en,
    input  logic [AW-1:0]    i_wr_addr,
    input  logic [width-1:0] i_wr_dat,
    input  logic             i_rd_en,
    input  logic [AW-1:0]    i_rd_addr,
    output logic [width-1:0] o_rd_dat
);

    logic [width-1:0] r_mem [depth];
    logic [width-1:0] r_rd_dat;

    // Storage is deliberately left out of reset; only the output register is cleared.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_dat <= '0;
        end else if (i_rd_en) begin
            r_rd_dat <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_dat = r_rd_dat;

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read data; one-cycle read latency, no fall-through.
// Writes while full and reads while empty are silently dropped; flags decode from registered pointers.
module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter int width = DEF_WIDTH,
    parameter int depth = DEF_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             w_en,
    input  logic             r_en,
    input  logic [width-1:0] data_in,
    output logic [width-1:0] data_out,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(depth);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [AW:0] r_wptr;
    logic [AW:0] r_rptr;
    logic        w_full;
    logic        w_empty;
    logic        w_wr_acc;
    logic        w_rd_acc;

    // The extra MSB distinguishes a full wrap from empty when the address bits match.
    assign w_empty  = (r_wptr == r_rptr);
    assign w_full   = (r_wptr[AW-1:0] == r_rptr[AW-1:0]) && (r_wptr[AW] != r_rptr[AW]);
    assign w_wr_acc = w_en && !w_full;
    assign w_rd_acc = r_en && !w_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_wr_acc) begin
                r_wptr <= r_wptr + PTR_ONE;
            end
            if (w_rd_acc) begin
                r_rptr <= r_rptr + PTR_ONE;
            end
        end
    end

    sync_fifo_mem #(
        .width (width),
        .depth (depth)
    ) u_mem (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (w_wr_acc),
        .i_wr_addr (r_wptr[AW-1:0]),
        .i_wr_dat  (data_in),
        .i_rd_en   (w_rd_acc),
        .i_rd_addr (r_rptr[AW-1:0]),
        .o_rd_dat  (data_out)
    );

    assign full  = w_full;
    assign empty = w_empty;

endmodule

// File: tb/tb_sync_fifo.sv
// Scoreboard bench for sync_fifo: expected words queued on accepted writes, popped on accepted reads.
module tb_sync_fifo;

    localparam int WIDTH = 8;
    localparam int DEPTH = 8;

    logic             clk;
    logic             rst;
    logic             w_en;
    logic             r_en;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] data_out;
    logic             full;
    logic             empty;

    logic [WIDTH-1:0] sb_q [$];
    logic [WIDTH-1:0] exp_dout;
    int               n_checks;
    int               n_errors;

    sync_fifo #(
        .width (WIDTH),
        .depth (DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .w_en     (w_en),
        .r_en     (r_en),
        .data_in  (data_in),
        .data_out (data_out),
        .full     (full),
        .empty    (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock: drive inputs, advance the scoreboard with pre-edge acceptance, then check outputs.
    task automatic step(input logic r, input logic we, input logic re, input logic [WIDTH-1:0] d);
        bit wr_ok;
        bit rd_ok;
        rst     = r;
        w_en    = we;
        r_en    = re;
        data_in = d;
        wr_ok   = !r && we && (sb_q.size() < DEPTH);
        rd_ok   = !r && re && (sb_q.size() > 0);
        @(posedge clk);
        #1;
        if (r) begin
            sb_q.delete();
            exp_dout = '0;
        end else begin
            if (rd_ok) exp_dout = sb_q.pop_front();
            if (wr_ok) sb_q.push_back(d);
        end
        chk("data_out", 32'(data_out), 32'(exp_dout));
        chk("full",     32'(full),     32'(sb_q.size() == DEPTH));
        chk("empty",    32'(empty),    32'(sb_q.size() == 0));
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        exp_dout = '0;
        rst      = 1'b1;
        w_en     = 1'b0;
        r_en     = 1'b0;
        data_in  = '0;

        // Reset held for two edges.
        step(1'b1, 1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b0, 1'b0, 8'h00);

        // Fill 1..8, then attempt overflow.
        for (int i = 1; i <= DEPTH; i++) step(1'b0, 1'b1, 1'b0, WIDTH'(i));
        chk("full_after_fill", 32'(full), 32'd1);
        step(1'b0, 1'b1, 1'b0, 8'hAA);
        step(1'b0, 1'b1, 1'b0, 8'hAA);

        // Drain, plus an extra read while empty that must leave data_out at 8.
        for (int i = 1; i <= DEPTH; i++) step(1'b0, 1'b0, 1'b1, 8'h00);
        chk("last_drained", 32'(data_out), 32'd8);
        step(1'b0, 1'b0, 1'b1, 8'h00);
        chk("read_empty_hold", 32'(data_out), 32'd8);

        // Write 1..5, read 3, then 10 simultaneous cycles crossing the pointer wrap.
        for (int i = 1; i <= 5; i++) step(1'b0, 1'b1, 1'b0, WIDTH'(i));
        for (int i = 0; i < 3; i++)  step(1'b0, 1'b0, 1'b1, 8'h00);
        for (int i = 6; i <= 15; i++) step(1'b0, 1'b1, 1'b1, WIDTH'(i));
        chk("occupancy_const", 32'(sb_q.size()), 32'd2);
        step(1'b0, 1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b0, 1'b1, 8'h00);
        chk("wrap_tail", 32'(data_out), 32'd15);

        // Both enables on an empty FIFO: only the write happens.
        step(1'b0, 1'b1, 1'b1, 8'h77);
        chk("empty_both_dout", 32'(data_out), 32'd15);
        step(1'b0, 1'b0, 1'b1, 8'h00);

        // Simultaneous access while full: read wins, write dropped.
        for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 1'b0, WIDTH'(8'h30 + i));
        step(1'b0, 1'b1, 1'b1, 8'hEE);
        for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b0, 1'b1, 8'h00);

        // Mid-operation reset.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, WIDTH'(8'h40 + i));
        step(1'b0, 1'b0, 1'b1, 8'h00);
        step(1'b1, 1'b0, 1'b0, 8'h00);
        chk("reset_dout", 32'(data_out), 32'd0);
        step(1'b0, 1'b1, 1'b0, 8'h5C);
        step(1'b0, 1'b0, 1'b1, 8'h00);
        chk("post_reset_data", 32'(data_out), 32'h5C);

        // Random traffic to exercise arbitrary occupancy and repeated wraps.
        for (int i = 0; i < 400; i++) begin
            step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), WIDTH'($urandom));
        end
        while (sb_q.size() > 0) step(1'b0, 1'b0, 1'b1, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
